uart_core_param: RTL and testbench
==================================

// Module: uart_core_param
// PURPOSE
// - Parametrised full-duplex UART; successor to the fixed 8N1 uart block.
// - Configurable data width, parity mode, stop bits and baud divisor.
// - Ready/valid handshakes on both directions; glitch-rejecting RX with mid-bit sampling.
// - Reports framing, parity and overrun errors.
// - Sits between the comms fabric and the board rx/tx pins.
// PARAMETERS
// CLKS_PER_BIT  868  clk cycles per bit (>=4); 100 MHz / 115200 baud
// DATA_BITS     8    payload bits per frame, 5..8
// PARITY        0    0 = none, 1 = even, 2 = odd
// STOP_BITS     1    stop bits, 1 or 2; RX checks only the first
// PORTS
// clk            in   1  system clock
// reset_n        in   1  asynchronous, active-low reset
// tx_data        in   8  TX payload; bits above DATA_BITS-1 ignored
// tx_valid       in   1  TX payload valid
// tx_ready       out  1  TX can accept a payload
// tx             out  1  serial out, idle high
// rx             in   1  serial in, asynchronous to clk
// rx_data        out  8  received payload, zero-extended above DATA_BITS-1
// rx_valid       out  1  rx_data and the error flags are valid
// rx_ready       in   1  consumer accepts rx_data
// rx_frame_err   out  1  first stop bit sampled 0 (qualified by rx_valid)
// rx_parity_err  out  1  parity mismatch (qualified by rx_valid; always 0 if PARITY=0)
// rx_overrun     out  1  one-cycle pulse: a completed frame was dropped
// BEHAVIOUR
// - Reset (async assert, sync release) values:
//   - tx = 1, tx_ready = 1.
//   - rx_valid = 0, rx_data = 0, all error flags = 0.
//   - Both FSMs in IDLE; rx synchroniser flops = 1.
//   - Reset mid-frame aborts the frame; tx returns high immediately.
// - TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   - Accept on tx_valid & tx_ready. tx_ready drops the next cycle; START drives tx = 0 in that same cycle.
//   - Each bit lasts exactly CLKS_PER_BIT cycles. Data goes out LSB first.
//   - Parity is XOR of the data bits; inverted for odd.
//   - STOP holds tx = 1 for STOP_BITS*CLKS_PER_BIT cycles. tx_ready rises on the cycle STOP ends.
//   - Back-to-back frames therefore have zero idle gap.
// - RX synchronisation: rx passes through 2 flops before use; pin-to-detection latency is 2 clk.
// - RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   - IDLE: a synchronised 1->0 edge starts the bit counter.
//   - START: sample at count CLKS_PER_BIT/2. If rx is high, treat it as a glitch and return to IDLE with no flags.
//   - All later bits are sampled at mid-bit, i.e. every CLKS_PER_BIT cycles after the start sample.
//   - STOP: at the mid-bit sample, load rx_data and the error flags and go to IDLE. The second stop bit is not awaited.
// - RX output register (one deep):
//   - rx_valid rises on the load cycle and holds until rx_valid & rx_ready.
//   - A load while rx_valid & !rx_ready keeps the old data, drops the new frame and pulses rx_overrun.
//   - A load in the same cycle as rx_valid & rx_ready replaces the data, keeps rx_valid = 1, and gives no overrun.
//   - A frame with a framing or parity error is still delivered, with its flag set.
// - Counters: bit counter is $clog2(CLKS_PER_BIT) wide. Data index is 3 bits and wraps at DATA_BITS-1 into the next state.
// - TX and RX are fully independent; simultaneous activity is allowed.
// STRUCTURE
// - uartshare.v holds:
//   - the PARITY_NONE/EVEN/ODD encodings;
//   - the TX/RX state localparams;
//   - default CLKS_PER_BIT.
// - commsshare.v holds clock period constants for benches.
// - Sub-module uart_bit_timer: counter with load/clear, emitting mid-bit and end-of-bit strobes. One instance each in TX and RX.
// - TX and RX FSMs are inline in uart_core_param.
// TESTING (CLKS_PER_BIT=16 for speed)
// 1. Reset:
//    - Assert reset_n low mid-TX-frame -> tx = 1, tx_ready = 1, rx_valid = 0 within the same cycle.
// 2. 8N1 loopback:
//    - Stimulus: tie tx to rx, send 0xA5.
//    - Expect: tx pattern 0,1,0,1,0,0,1,0,1,1 at 16 clk per bit; rx_valid with rx_data = 0xA5, no error flags.
// 3. 7E2:
//    - Stimulus: send 0x55.
//    - Expect: parity bit 0, two stop bits, rx_data = 0x55.
//    - Stimulus: flip the parity bit on the wire.
//    - Expect: rx_parity_err = 1, data still delivered.
// 4. Framing error and glitch rejection:
//    - Stimulus: drive stop bit = 0.
//    - Expect: rx_frame_err = 1.
//    - Stimulus: a 3-clk low pulse while idle.
//    - Expect: no rx_valid.
// 5. Overrun:
//    - Stimulus: hold rx_ready = 0 and receive 0x11, then 0x22.
//    - Expect: rx_overrun pulses once; rx_data stays 0x11.
// 6. Back-to-back TX:
//    - Stimulus: hold tx_valid high for 0x01 then 0x02.
//    - Expect: second start bit directly follows the stop bit, no idle gap.

Source files
------------

// File: rtl/uart_core_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_core_param_pkg
// Description : Shared encodings for the parametrised UART: parity modes,
//               FSM state codes, default bit timing and a parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_core_param_pkg;

    // Parity mode encodings for the PARITY parameter
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // 100 MHz clock, 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    // Clock period used by benches driving this block
    localparam int CLK_PERIOD_NS = 10;

    // State codes shared by the TX and RX frame FSMs
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Parity bit for a payload whose unused upper bits are already zero
    function automatic logic frame_parity(input logic [7:0] data, input int mode);
        return (^data) ^ (mode == PARITY_ODD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_bit_timer
// Description : Free-running bit-period counter with synchronous clear.
//               Emits a mid-bit strobe and an end-of-bit strobe while running.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer
    import uart_core_param_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic mid,
    output logic last
);

    localparam int              CW         = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   MID_COUNT  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0]   LAST_COUNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    // Count cycles within a bit; clear restarts the period at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= (count == LAST_COUNT) ? '0 : count + 1'b1;
        end
    end

    assign mid  = run && (count == MID_COUNT);
    assign last = run && (count == LAST_COUNT);

endmodule
`default_nettype wire

// File: rtl/uart_core_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_core_param
// Description : Parametrised full-duplex UART with ready/valid handshakes,
//               mid-bit sampling RX with glitch rejection, and framing,
//               parity and overrun reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_core_param
    import uart_core_param_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PARITY_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_parity_err,
    output logic       rx_overrun
);

    localparam logic [7:0] DATA_MASK = 8'hFF >> (8 - DATA_BITS);
    localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic       HAS_PAR   = (PARITY != PARITY_NONE);

    // Reset: asserts immediately, releases two clocks later in this domain
    logic [1:0] rst_pipe;
    logic       rst_n;

    // Reset release synchroniser
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_pipe <= 2'b00;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    // ------------------------------------------------------------------ TX
    logic [2:0] tx_state;
    logic [7:0] tx_shift;
    logic [2:0] tx_idx;
    logic       tx_stop_cnt;
    logic       tx_par;
    logic       tx_busy, tx_bit_end, tx_mid_unused, tx_accept, tx_stop_done;

    // Ready stays high through the final stop cycle so frames can abut
    assign tx_busy      = (tx_state != ST_IDLE);
    assign tx_stop_done = (tx_state == ST_STOP) && tx_bit_end && (tx_stop_cnt == STOP_LAST);
    assign tx_ready     = !tx_busy || tx_stop_done;
    assign tx_accept    = tx_valid && tx_ready;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (tx_accept),
        .run   (tx_busy),
        .mid   (tx_mid_unused),
        .last  (tx_bit_end)
    );

    // TX frame sequencer: start, LSB-first data, optional parity, stop(s)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state    <= ST_IDLE;
            tx          <= 1'b1;
            tx_shift    <= '0;
            tx_idx      <= '0;
            tx_stop_cnt <= 1'b0;
            tx_par      <= 1'b0;
        end else if (tx_accept) begin
            tx_state    <= ST_START;
            tx          <= 1'b0;
            tx_shift    <= tx_data & DATA_MASK;
            tx_idx      <= '0;
            tx_stop_cnt <= 1'b0;
            tx_par      <= frame_parity(tx_data & DATA_MASK, PARITY);
        end else if (tx_bit_end) begin
            case (tx_state)
                ST_START: begin
                    tx_state <= ST_DATA;
                    tx       <= tx_shift[0];
                    tx_shift <= {1'b0, tx_shift[7:1]};
                end
                ST_DATA: begin
                    if (tx_idx == LAST_IDX) begin
                        tx_state <= HAS_PAR ? ST_PARITY : ST_STOP;
                        tx       <= HAS_PAR ? tx_par : 1'b1;
                    end else begin
                        tx_idx   <= tx_idx + 3'd1;
                        tx       <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                    end
                end
                ST_PARITY: begin
                    tx_state <= ST_STOP;
                    tx       <= 1'b1;
                end
                ST_STOP: begin
                    if (tx_stop_cnt == STOP_LAST) tx_state <= ST_IDLE;
                    else                          tx_stop_cnt <= 1'b1;
                end
                default: begin
                    tx_state <= ST_IDLE;
                    tx       <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------ RX
    logic       rx_meta, rx_sync, rx_prev;
    logic [2:0] rx_state;
    logic [2:0] rx_idx;
    logic [7:0] rx_shift;
    logic       rx_par_bit;
    logic       rx_start, rx_mid, rx_last_unused, rx_load, rx_perr_now, rx_drop;

    // Two-flop synchroniser plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_start = (rx_state == ST_IDLE) && rx_prev && !rx_sync;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (rx_start),
        .run   (rx_state != ST_IDLE),
        .mid   (rx_mid),
        .last  (rx_last_unused)
    );

    // RX frame sequencer: every decision is taken on the mid-bit strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= ST_IDLE;
            rx_idx     <= '0;
            rx_shift   <= '0;
            rx_par_bit <= 1'b0;
        end else begin
            case (rx_state)
                ST_IDLE: if (rx_start) rx_state <= ST_START;
                ST_START: if (rx_mid) begin
                    if (rx_sync) begin
                        rx_state <= ST_IDLE;       // start bit vanished: glitch
                    end else begin
                        rx_state <= ST_DATA;
                        rx_idx   <= '0;
                        rx_shift <= '0;
                    end
                end
                ST_DATA: if (rx_mid) begin
                    rx_shift[rx_idx] <= rx_sync;
                    if (rx_idx == LAST_IDX) rx_state <= HAS_PAR ? ST_PARITY : ST_STOP;
                    else                    rx_idx   <= rx_idx + 3'd1;
                end
                ST_PARITY: if (rx_mid) begin
                    rx_par_bit <= rx_sync;
                    rx_state   <= ST_STOP;
                end
                ST_STOP: if (rx_mid) rx_state <= ST_IDLE;
                default: rx_state <= ST_IDLE;
            endcase
        end
    end

    assign rx_load     = (rx_state == ST_STOP) && rx_mid;
    assign rx_perr_now = HAS_PAR && (frame_parity(rx_shift, PARITY) != rx_par_bit);
    assign rx_drop     = rx_valid && !rx_ready;

    // One-deep output register; a frame arriving while full is discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_overrun <= rx_load && rx_drop;
            if (rx_load && !rx_drop) begin
                rx_valid      <= 1'b1;
                rx_data       <= rx_shift;
                rx_frame_err  <= !rx_sync;
                rx_parity_err <= rx_perr_now;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_core_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_core_param
// Description : Directed self-checking bench for uart_core_param with an
//               8N1 instance and a 7E2 instance at 16 clocks per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_core_param;
    import uart_core_param_pkg::*;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic reset_n;

    logic [7:0] tx_data8, rx_data8, tx_data7, rx_data7;
    logic tx_valid8, tx_ready8, tx8, rx8, rx_drv8, loop8, rx_valid8, rx_ready8;
    logic rx_ferr8, rx_perr8, rx_ovr8;
    logic tx_valid7, tx_ready7, tx7, rx7, rx_drv7, loop7, rx_valid7, rx_ready7;
    logic rx_ferr7, rx_perr7, rx_ovr7;

    int checks = 0;
    int errors = 0;
    int ovr_count8 = 0;
    int ovr_base;

    assign rx8 = loop8 ? tx8 : rx_drv8;
    assign rx7 = loop7 ? tx7 : rx_drv7;

    always #(CLK_PERIOD_NS / 2) clk = ~clk;

    uart_core_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(1)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
        .tx(tx8), .rx(rx8), .rx_data(rx_data8), .rx_valid(rx_valid8), .rx_ready(rx_ready8),
        .rx_frame_err(rx_ferr8), .rx_parity_err(rx_perr8), .rx_overrun(rx_ovr8)
    );

    uart_core_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PARITY_EVEN), .STOP_BITS(2)) u_dut7 (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data7), .tx_valid(tx_valid7), .tx_ready(tx_ready7),
        .tx(tx7), .rx(rx7), .rx_data(rx_data7), .rx_valid(rx_valid7), .rx_ready(rx_ready7),
        .rx_frame_err(rx_ferr7), .rx_parity_err(rx_perr7), .rx_overrun(rx_ovr7)
    );

    // Count overrun pulses on the 8N1 instance
    always @(negedge clk) if (rx_ovr8 === 1'b1) ovr_count8 <= ovr_count8 + 1;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive n wire bits (LSB first) onto an rx pin, then return it to idle
    task automatic drive_frame(input int which, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 8) rx_drv8 = bits[i]; else rx_drv7 = bits[i];
            repeat (CPB) @(negedge clk);
        end
        if (which == 8) rx_drv8 = 1'b1; else rx_drv7 = 1'b1;
    endtask

    // Called in the first START cycle; samples tx at the middle of each bit
    task automatic check_tx_bits(input int which, input string tag, input logic [15:0] bits, input int n);
        repeat (CPB / 2) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_bit%0d", tag, k), (which == 8) ? tx8 : tx7, bits[k]);
            if (k < n - 1) repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic wait_valid(input int which, input string tag, input int max);
        int n = 0;
        while ((((which == 8) ? rx_valid8 : rx_valid7) !== 1'b1) && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, (which == 8) ? rx_valid8 : rx_valid7, 8'd1);
    endtask

    task automatic consume(input int which, input string tag);
        if (which == 8) rx_ready8 = 1'b1; else rx_ready7 = 1'b1;
        @(negedge clk);
        if (which == 8) rx_ready8 = 1'b0; else rx_ready7 = 1'b0;
        check(tag, (which == 8) ? rx_valid8 : rx_valid7, 8'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        tx_data8 = 8'h00; tx_valid8 = 1'b0; rx_drv8 = 1'b1; loop8 = 1'b0; rx_ready8 = 1'b0;
        tx_data7 = 8'h00; tx_valid7 = 1'b0; rx_drv7 = 1'b1; loop7 = 1'b0; rx_ready7 = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx", tx8, 8'd1);
        check("rst_tx_ready", tx_ready8, 8'd1);
        check("rst_rx_valid", rx_valid8, 8'd0);
        check("rst_rx_data", rx_data8, 8'h00);
        check("rst_errs", {5'd0, rx_ferr8, rx_perr8, rx_ovr8}, 8'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1 loopback of 0xA5
        loop8 = 1'b1;
        tx_data8 = 8'hA5; tx_valid8 = 1'b1;
        check("a5_ready_idle", tx_ready8, 8'd1);
        @(negedge clk);
        tx_valid8 = 1'b0;
        check("a5_ready_drop", tx_ready8, 8'd0);
        check_tx_bits(8, "a5", 16'({1'b1, 8'hA5, 1'b0}), 10);  // now at cycle 152
        repeat (6) @(negedge clk);
        check("a5_ready_158", tx_ready8, 8'd0);
        @(negedge clk);
        check("a5_ready_159", tx_ready8, 8'd1);
        wait_valid(8, "a5_rx_valid", 40);
        check("a5_rx_data", rx_data8, 8'hA5);
        check("a5_rx_errs", {6'd0, rx_ferr8, rx_perr8}, 8'd0);
        consume(8, "a5_consume");
        loop8 = 1'b0;

        // 7E2 loopback; bit 7 of the payload is outside the frame
        loop7 = 1'b1;
        tx_data7 = 8'hD5; tx_valid7 = 1'b1;
        @(negedge clk);
        tx_valid7 = 1'b0;
        check_tx_bits(7, "d5", 16'({2'b11, 1'b0, 7'h55, 1'b0}), 11);  // now at cycle 168
        repeat (6) @(negedge clk);
        check("e2_ready_174", tx_ready7, 8'd0);
        @(negedge clk);
        check("e2_ready_175", tx_ready7, 8'd1);
        wait_valid(7, "e2_rx_valid", 40);
        check("e2_rx_data", rx_data7, 8'h55);
        check("e2_rx_errs", {6'd0, rx_ferr7, rx_perr7}, 8'd0);
        consume(7, "e2_consume");
        loop7 = 1'b0;

        // 7E2 with the parity bit inverted on the wire
        drive_frame(7, 16'({2'b11, 1'b1, 7'h55, 1'b0}), 11);
        wait_valid(7, "perr_valid", 40);
        check("perr_flag", rx_perr7, 8'd1);
        check("perr_data", rx_data7, 8'h55);
        check("perr_ferr", rx_ferr7, 8'd0);
        consume(7, "perr_consume");

        // Framing error: stop bit driven low
        drive_frame(8, 16'({1'b0, 8'h3C, 1'b0}), 10);
        wait_valid(8, "ferr_valid", 40);
        check("ferr_flag", rx_ferr8, 8'd1);
        check("ferr_data", rx_data8, 8'h3C);
        check("ferr_perr", rx_perr8, 8'd0);
        consume(8, "ferr_consume");

        // 3-clock low glitch while idle must not produce a frame
        rx_drv8 = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv8 = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_valid", rx_valid8, 8'd0);

        // Overrun: second frame dropped while the first is unread
        drive_frame(8, 16'({1'b1, 8'h11, 1'b0}), 10);
        wait_valid(8, "ovr_first_valid", 40);
        check("ovr_first_data", rx_data8, 8'h11);
        ovr_base = ovr_count8;
        drive_frame(8, 16'({1'b1, 8'h22, 1'b0}), 10);
        repeat (20) @(negedge clk);
        check("ovr_pulses", 8'(ovr_count8 - ovr_base), 8'd1);
        check("ovr_data_kept", rx_data8, 8'h11);
        check("ovr_valid_held", rx_valid8, 8'd1);

        // Back-to-back TX: second start bit directly after the stop bit
        tx_data8 = 8'h01; tx_valid8 = 1'b1;
        @(negedge clk);
        tx_data8 = 8'h02;
        check("b2b_start1", tx8, 8'd0);
        repeat (152) @(negedge clk);
        check("b2b_stop1_mid", tx8, 8'd1);
        repeat (7) @(negedge clk);
        check("b2b_ready_159", tx_ready8, 8'd1);
        check("b2b_stop1_last", tx8, 8'd1);
        @(negedge clk);
        tx_valid8 = 1'b0;
        check("b2b_start2", tx8, 8'd0);
        check("b2b_ready_160", tx_ready8, 8'd0);
        repeat (24) @(negedge clk);
        check("b2b_f2_d0", tx8, 8'd0);
        repeat (16) @(negedge clk);
        check("b2b_f2_d1", tx8, 8'd1);
        repeat (150) @(negedge clk);
        check("b2b_idle_ready", tx_ready8, 8'd1);

        // Reset in the middle of a TX frame with RX data pending
        tx_data8 = 8'h00; tx_valid8 = 1'b1;
        @(negedge clk);
        tx_valid8 = 1'b0;
        repeat (40) @(negedge clk);
        check("mid_pre_tx", tx8, 8'd0);
        check("mid_pre_rx_valid", rx_valid8, 8'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_tx", tx8, 8'd1);
        check("mid_rst_tx_ready", tx_ready8, 8'd1);
        check("mid_rst_rx_valid", rx_valid8, 8'd0);
        check("mid_rst_rx_data", rx_data8, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_tx", tx8, 8'd1);
        check("post_rst_tx_ready", tx_ready8, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
